req_encoder_32x5: RTL and testbench

REQ_ENCODER_32X5 -- requirements
Module: req_encoder_32x5

---
 rtl/req_encoder_32x5.sv | 94 +++++++++
 tb/tb_req_encoder_32x5.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/req_encoder_32x5.sv
// 32-bit pending-request latch with a registered priority encoder and
// a valid/ack handshake that issues one grant per cycle back-to-back.
module req_encoder_32x5 #(
    parameter int LSB_PRIORITY = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] REQ,
    input  logic [31:0] MASK,
    input  logic        ACK,
    output logic        VALID,
    output logic [4:0]  INDEX,
    output logic [31:0] PEND,
    output logic        COALESCE
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  index_q, index_d;
    logic [31:0] pend_q, pend_d;
    logic        coalesce_q, coalesce_d;

    logic [31:0] clr;
    logic [31:0] kept;
    logic [31:0] elig;
    logic [4:0]  sel;

    always_comb begin
        clr = '0;
        if (state_q == HOLD && ACK) begin
            clr[index_q] = 1'b1;
        end
        kept = pend_q & ~clr;
        // Only registered PEND is eligible; same-cycle REQ waits a cycle.
        elig = kept & MASK;

        sel = '0;
        for (int i = 0; i < 32; i++) begin
            if (LSB_PRIORITY != 0) begin
                if (elig[31-i]) sel = 5'(31 - i);
            end else begin
                if (elig[i]) sel = 5'(i);
            end
        end

        pend_d     = kept | REQ;
        coalesce_d = coalesce_q | (|(REQ & kept));

        state_d = state_q;
        index_d = index_q;
        unique case (state_q)
            IDLE: begin
                if (|elig) begin
                    state_d = HOLD;
                    index_d = sel;
                end
            end
            HOLD: begin
                if (ACK) begin
                    if (|elig) begin
                        index_d = sel;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            index_q    <= '0;
            pend_q     <= '0;
            coalesce_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            pend_q     <= pend_d;
            coalesce_q <= coalesce_d;
        end
    end

    assign VALID    = (state_q == HOLD);
    assign INDEX    = index_q;
    assign PEND     = pend_q;
    assign COALESCE = coalesce_q;

endmodule

// File: tb/tb_req_encoder_32x5.sv
// Scoreboard bench: stimulus queues expected grant indices, a negedge
// monitor pops one for every VALID&&ACK handshake it observes.
module tb_req_encoder_32x5;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] REQ;
    logic [31:0] MASK;
    logic        ACK;
    logic        VALID;
    logic [4:0]  INDEX;
    logic [31:0] PEND;
    logic        COALESCE;

    int checks   = 0;
    int failures = 0;
    logic [4:0] exp_q[$];

    req_encoder_32x5 #(.LSB_PRIORITY(1)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .MASK(MASK), .ACK(ACK),
        .VALID(VALID), .INDEX(INDEX), .PEND(PEND), .COALESCE(COALESCE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (!RESET && VALID && ACK) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_grant", 32'(INDEX), 32'hFFFF_FFFF);
            end else begin
                chk("grant_index", 32'(INDEX), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; REQ = '0; MASK = '1; ACK = 1'b0;
        #12;
        chk("rst_valid", 32'(VALID), 32'd0);
        chk("rst_index", 32'(INDEX), 32'd0);
        chk("rst_pend", PEND, 32'd0);
        chk("rst_coal", 32'(COALESCE), 32'd0);
        tick();
        RESET = 1'b0;

        // single request, two-edge latency
        REQ = 32'h0000_0100;
        tick(); REQ = '0;
        chk("lat_pend", PEND, 32'h0000_0100);
        chk("lat_valid0", 32'(VALID), 32'd0);
        tick();
        chk("lat_valid1", 32'(VALID), 32'd1);
        chk("lat_index", 32'(INDEX), 32'd8);
        exp_q.push_back(5'd8); ACK = 1'b1;
        tick(); ACK = 1'b0;
        chk("ack_valid", 32'(VALID), 32'd0);
        chk("ack_pend", PEND, 32'd0);

        // three bits, ACK held: 0,4,31 back-to-back
        REQ = 32'h8000_0011; ACK = 1'b1;
        exp_q.push_back(5'd0); exp_q.push_back(5'd4); exp_q.push_back(5'd31);
        tick(); REQ = '0;
        chk("idle_ack_pend", PEND, 32'h8000_0011);
        chk("idle_ack_valid", 32'(VALID), 32'd0);
        tick(); chk("seq0", {VALID, 26'd0, INDEX}, {1'b1, 26'd0, 5'd0});
        tick(); chk("seq1", {VALID, 26'd0, INDEX}, {1'b1, 26'd0, 5'd4});
        tick(); chk("seq2", {VALID, 26'd0, INDEX}, {1'b1, 26'd0, 5'd31});
        tick(); ACK = 1'b0;
        chk("seq_idle", 32'(VALID), 32'd0);
        chk("seq_pend", PEND, 32'd0);

        // higher-priority arrival does not disturb a held grant
        REQ = 32'h0000_0020;
        tick(); REQ = '0;
        tick();
        chk("hold_idx5", 32'(INDEX), 32'd5);
        REQ = 32'h0000_0002;
        tick(); REQ = '0;
        chk("hold_stays5", {VALID, 26'd0, INDEX}, {1'b1, 26'd0, 5'd5});
        chk("hold_pend", PEND, 32'h0000_0022);
        exp_q.push_back(5'd5); exp_q.push_back(5'd1); ACK = 1'b1;
        tick();
        chk("hold_next1", {VALID, 26'd0, INDEX}, {1'b1, 26'd0, 5'd1});
        tick(); ACK = 1'b0;
        chk("hold_idle", 32'(VALID), 32'd0);

        // masked bit latched but not granted until unmasked
        MASK = 32'hFFFF_FFFE; REQ = 32'h0000_0001;
        tick(); REQ = '0;
        tick();
        chk("mask_pend", PEND, 32'h0000_0001);
        chk("mask_valid", 32'(VALID), 32'd0);
        MASK = '1;
        tick();
        chk("unmask", {VALID, 26'd0, INDEX}, {1'b1, 26'd0, 5'd0});
        exp_q.push_back(5'd0); ACK = 1'b1;
        tick(); ACK = 1'b0;
        chk("unmask_pend", PEND, 32'd0);
        chk("coal_clean", 32'(COALESCE), 32'd0);

        // request held through its own ack: set wins, coalesce sticks
        REQ = 32'h0000_0008;
        tick(); tick();
        chk("coal_idx", {VALID, 26'd0, INDEX}, {1'b1, 26'd0, 5'd3});
        exp_q.push_back(5'd3); ACK = 1'b1;
        tick(); ACK = 1'b0; REQ = '0;
        chk("coal_pend", PEND, 32'h0000_0008);
        chk("coal_flag", 32'(COALESCE), 32'd1);
        tick();
        chk("coal_regrant", {VALID, 26'd0, INDEX}, {1'b1, 26'd0, 5'd3});
        exp_q.push_back(5'd3); ACK = 1'b1;
        tick(); ACK = 1'b0;
        chk("coal_drain", PEND, 32'd0);
        chk("coal_sticky", 32'(COALESCE), 32'd1);

        // asynchronous reset mid-HOLD
        REQ = 32'h0000_0220;
        tick(); REQ = '0;
        tick();
        chk("pre_rst", {VALID, 26'd0, INDEX}, {1'b1, 26'd0, 5'd5});
        ACK = 1'b1;
        #2 RESET = 1'b1;
        #1;
        chk("arst_valid", 32'(VALID), 32'd0);
        chk("arst_index", 32'(INDEX), 32'd0);
        chk("arst_pend", PEND, 32'd0);
        chk("arst_coal", 32'(COALESCE), 32'd0);
        ACK = 1'b0;
        tick(); RESET = 1'b0;
        REQ = 32'h0000_0004;
        tick(); REQ = '0;
        chk("post_rst_pend", PEND, 32'h0000_0004);
        tick();
        chk("post_rst_idx", {VALID, 26'd0, INDEX}, {1'b1, 26'd0, 5'd2});
        exp_q.push_back(5'd2); ACK = 1'b1;
        tick(); ACK = 1'b0;
        chk("post_rst_idle", 32'(VALID), 32'd0);

        // all 32 pending: 32 consecutive grants in order
        REQ = '1; ACK = 1'b1;
        for (int i = 0; i < 32; i++) exp_q.push_back(5'(i));
        tick(); REQ = '0;
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("burst", {VALID, 26'd0, INDEX}, {1'b1, 26'd0, 5'(i)});
        end
        tick(); ACK = 1'b0;
        chk("burst_idle", 32'(VALID), 32'd0);
        chk("burst_pend", PEND, 32'd0);

        tick(); tick();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
